gray_counter: RTL and testbench

Gray-code counter that advances once per single-cycle tick strobe from the upstream clock divider, all in the system clock domain. It keeps a binary count and a registered, glitch-free Gray encoding of it, and supports direction control, synchronous load, and wrap or saturate behaviour at the limits. Its outputs drive the display/LED stage of the Gray counter design.

---
 rtl/gray_counter.sv | 109 ++++++++++
 tb/tb_gray_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Purpose:
//   Gray-code counter that advances once per single-cycle tick strobe from the
//   upstream clock divider. Keeps a binary count and a registered Gray encoding
//   of it. Supports up/down direction, synchronous load, and wrap or saturate
//   behaviour at the count limits. All outputs come straight from flops.
//
// Parameters:
//   WIDTH  counter width in bits (>= 2)
//   WRAP   1 = wrap around at the limits, 0 = saturate at the limits
//
// Ports:
//   i_clk       in   1      system clock
//   i_rst       in   1      synchronous active-high reset
//   i_tick      in   1      one-cycle advance strobe
//   i_en        in   1      count enable (tick ignored while low)
//   i_dir       in   1      direction, 1 = up, 0 = down
//   i_load      in   1      synchronous load strobe (overrides tick)
//   i_load_bin  in   WIDTH  binary value to load
//   o_bin       out  WIDTH  registered binary count
//   o_gray      out  WIDTH  registered Gray code of o_bin
//   o_tc        out  1      one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module gray_counter #(
   parameter int WIDTH = 4,
   parameter int WRAP  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_tick,
   input  logic             i_en,
   input  logic             i_dir,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_bin,
   output logic [WIDTH-1:0] o_bin,
   output logic [WIDTH-1:0] o_gray,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_tc;

   logic [WIDTH-1:0] w_nextBin;
   logic [WIDTH-1:0] w_nextGray;
   logic             w_nextTc;
   logic             w_advance;
   logic             w_atMax;
   logic             w_atMin;

   // A tick only counts when enabled; load always wins over a tick.
   assign w_advance = i_tick & i_en & ~i_load;
   assign w_atMax   = (r_bin == {WIDTH{1'b1}});
   assign w_atMin   = (r_bin == {WIDTH{1'b0}});

   // Next-state selection: load, then advance, then hold. At a limit the
   // terminal-count pulse fires whether the count wraps or is blocked.
   always_comb begin
      w_nextBin = r_bin;
      w_nextTc  = 1'b0;
      if (i_load) begin
         w_nextBin = i_load_bin;
      end else if (w_advance) begin
         if (i_dir) begin
            if (w_atMax) begin
               w_nextTc = 1'b1;
               if (WRAP != 0) begin
                  w_nextBin = {WIDTH{1'b0}};
               end
            end else begin
               w_nextBin = r_bin + 1'b1;
            end
         end else begin
            if (w_atMin) begin
               w_nextTc = 1'b1;
               if (WRAP != 0) begin
                  w_nextBin = {WIDTH{1'b1}};
               end
            end else begin
               w_nextBin = r_bin - 1'b1;
            end
         end
      end
   end

   // Gray is encoded from the next binary value so it can be registered on
   // the same edge as the binary count, keeping the output glitch-free.
   assign w_nextGray = w_nextBin ^ (w_nextBin >> 1);

   // Output registers; reset dominates any simultaneous load or tick.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bin  <= {WIDTH{1'b0}};
         r_gray <= {WIDTH{1'b0}};
         r_tc   <= 1'b0;
      end else begin
         r_bin  <= w_nextBin;
         r_gray <= w_nextGray;
         r_tc   <= w_nextTc;
      end
   end

   assign o_bin  = r_bin;
   assign o_gray = r_gray;
   assign o_tc   = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//
// Purpose:
//   Drives one saturating (WRAP = 0) and one wrapping (WRAP = 1) gray_counter
//   with identical stimulus and compares both against a behavioural model
//   built on integer arithmetic and a reflected-Gray lookup table.
// -----------------------------------------------------------------------------
module tb_gray_counter;

   localparam int WIDTH = 4;
   localparam int MODV  = 1 << WIDTH;
   localparam int MAXV  = MODV - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             tick;
   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] loadBin;

   logic [WIDTH-1:0] bin0, gray0, bin1, gray1;
   logic             tc0, tc1;

   int testsRun    = 0;
   int testsFailed = 0;

   // Model state, index 0 = saturating instance, index 1 = wrapping instance.
   int mBin[2];
   bit mTc[2];
   bit mChanged[2];
   int grayTable[MODV];
   logic [WIDTH-1:0] prevGray[2];

   // Free-running system clock.
   always #5 clk = ~clk;

   gray_counter #(.WIDTH(WIDTH), .WRAP(0)) dutSat (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_en(en), .i_dir(dir),
      .i_load(load), .i_load_bin(loadBin),
      .o_bin(bin0), .o_gray(gray0), .o_tc(tc0)
   );

   gray_counter #(.WIDTH(WIDTH), .WRAP(1)) dutWrap (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_en(en), .i_dir(dir),
      .i_load(load), .i_load_bin(loadBin),
      .o_bin(bin1), .o_gray(gray1), .o_tc(tc1)
   );

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reflected construction of the Gray sequence, independent of any XOR form.
   task automatic buildGrayTable();
      grayTable[0] = 0;
      grayTable[1] = 1;
      for (int n = 2; n < MODV; n = n * 2)
         for (int j = 0; j < n; j++)
            grayTable[n + j] = n | grayTable[n - 1 - j];
   endtask

   // Behavioural model: integer step with explicit limit handling.
   task automatic modelStep(input int k, input bit wrapMode);
      int target;
      mChanged[k] = 1'b0;
      if (rst) begin
         mBin[k] = 0;
         mTc[k]  = 1'b0;
      end else if (load) begin
         mBin[k] = int'(loadBin);
         mTc[k]  = 1'b0;
      end else if (tick && en) begin
         target = dir ? mBin[k] + 1 : mBin[k] - 1;
         if (target < 0 || target > MAXV) begin
            mTc[k] = 1'b1;
            if (wrapMode) begin
               mBin[k]     = (target + MODV) % MODV;
               mChanged[k] = 1'b1;
            end
         end else begin
            mBin[k]     = target;
            mTc[k]      = 1'b0;
            mChanged[k] = 1'b1;
         end
      end else begin
         mTc[k] = 1'b0;
      end
   endtask

   // One clock cycle: drive inputs, advance model on the edge, check #1 later.
   task automatic applyStimulus(input bit r, input bit t, input bit e, input bit d,
                                input bit l, input logic [WIDTH-1:0] lb);
      rst = r; tick = t; en = e; dir = d; load = l; loadBin = lb;
      prevGray[0] = gray0;
      prevGray[1] = gray1;
      @(posedge clk);
      modelStep(0, 1'b0);
      modelStep(1, 1'b1);
      #1;
      checkOutput("sat_bin",   32'(bin0),  32'(mBin[0]));
      checkOutput("sat_gray",  32'(gray0), 32'(grayTable[mBin[0]]));
      checkOutput("sat_tc",    32'(tc0),   32'(mTc[0]));
      checkOutput("wrap_bin",  32'(bin1),  32'(mBin[1]));
      checkOutput("wrap_gray", 32'(gray1), 32'(grayTable[mBin[1]]));
      checkOutput("wrap_tc",   32'(tc1),   32'(mTc[1]));
      if (!r && !l && mChanged[0])
         checkOutput("sat_onebit", 32'($countones(gray0 ^ prevGray[0])), 32'd1);
      if (!r && !l && mChanged[1])
         checkOutput("wrap_onebit", 32'($countones(gray1 ^ prevGray[1])), 32'd1);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, en, dir, 1'b0, '0);
   endtask

   initial begin
      int expSeq[16];
      expSeq = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
      rst = 1'b1; tick = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; loadBin = '0;
      mBin = '{0, 0}; mTc = '{1'b0, 1'b0};
      buildGrayTable();

      // Reset state.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      checkOutput("reset_bin",  32'(bin1),  32'd0);
      checkOutput("reset_gray", 32'(gray1), 32'd0);
      checkOutput("reset_tc",   32'(tc1),   32'd0);

      // Up-count through the full Gray sequence, ticks 5 cycles apart.
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
         checkOutput("seq_gray", 32'(gray1), 32'(expSeq[i % 16]));
         checkOutput("seq_tc",   32'(tc1),   32'(i == 16));
         idle(4);
      end

      // Down-wrap from reset.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      checkOutput("dwrap_bin",  32'(bin1),  32'd15);
      checkOutput("dwrap_gray", 32'(gray1), 32'b1000);
      checkOutput("dwrap_tc",   32'(tc1),   32'd1);
      idle(1);
      checkOutput("dwrap_tc_clr", 32'(tc1), 32'd0);

      // Load wins over a same-cycle tick.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
      checkOutput("ld_bin",  32'(bin1),  32'd9);
      checkOutput("ld_gray", 32'(gray1), 32'b1101);
      checkOutput("ld_tc",   32'(tc1),   32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      checkOutput("ld_next_bin",  32'(bin1),  32'd10);
      checkOutput("ld_next_gray", 32'(gray1), 32'b1111);

      // Enable gating.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
      checkOutput("en_hold", 32'(bin1), 32'd10);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      checkOutput("en_adv", 32'(bin1), 32'd11);

      // Saturation on the WRAP = 0 instance.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
         checkOutput("sat_up_bin", 32'(bin0), 32'd15);
         checkOutput("sat_up_tc",  32'(tc0),  32'd1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      checkOutput("sat_dn_bin", 32'(bin0), 32'd0);
      checkOutput("sat_dn_tc",  32'(tc0),  32'd1);

      // Reset dominates a simultaneous tick and load.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd12);
      checkOutput("rst_mid_bin",  32'(bin1),  32'd0);
      checkOutput("rst_mid_gray", 32'(gray1), 32'd0);
      checkOutput("rst_mid_tc",   32'(tc1),   32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 59) == 0,
                       $urandom_range(0, 2) != 0,
                       $urandom_range(0, 4) != 0,
                       1'($urandom_range(0, 1)),
                       $urandom_range(0, 11) == 0,
                       WIDTH'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
